// File: rtl/reg_bank_pkg.sv
// Shared types and default parameter values for the multi-port register bank.
package reg_bank_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_NREGS    = 32;
  localparam int unsigned DEF_NRD      = 2;
  localparam bit          DEF_ZERO_REG = 1'b1;
  localparam bit          DEF_BYPASS   = 1'b1;

  // CLEAR: the bank is sweeping zeros into every register, one per cycle.
  // READY: normal operation, writes accepted and stored data returned.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bank_state_e;

endpackage

// File: rtl/reg_bank_clr.sv
// Clear sequencer: walks idx from 0 to NREGS-1 while in CLEAR, then
// reports ready. Reset or a clr request in READY restarts the sweep.
// State, index and ready are all visible on ports for observation.
module reg_bank_clr
  import reg_bank_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output bank_state_e   state_o,
  output logic [AW-1:0] idx_o,
  output logic          ready_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  bank_state_e   state_q;
  logic [AW-1:0] idx_q;
  logic          ready_q;

  // Sweep sequencer; ready is registered so it flips on the same edge as state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          // clr is ignored here: an active sweep is never restarted by it.
          if (idx_q == LAST_IDX) begin
            state_q <= READY;
            idx_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        READY: begin
          if (clr_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign idx_o   = idx_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: one write port, NRD combinational read ports,
// optional hard-wired zero register and same-cycle write forwarding.
// Contents are zeroed by a sequential sweep rather than a parallel reset.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned NRD      = DEF_NRD,
  parameter bit          ZERO_REG = DEF_ZERO_REG,
  parameter bit          BYPASS   = DEF_BYPASS,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       a3,
  input  logic [XLEN-1:0]     wd3,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                clr,
  output logic                ready
);

  bank_state_e   state;
  logic [AW-1:0] idx;
  logic          clearing;
  logic          user_wr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] mem_q [NREGS];

  reg_bank_clr #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .state_o (state),
    .idx_o   (idx),
    .ready_o (ready)
  );

  assign clearing = (state == CLEAR);

  // A user write lands only in READY, loses to clr, and skips the zero register.
  assign user_wr = ready && we && !clr && !(ZERO_REG && (a3 == '0));

  // Select between the clear sweep and the user write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = a3;
    wr_data = wd3;
    if (rst_n) begin
      if (clearing) begin
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_data = '0;
      end else if (user_wr) begin
        wr_en = 1'b1;
      end
    end
  end

  // Storage update; no parallel reset, the sweep does the zeroing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = ra[k*AW +: AW];

    // Read mux: gated to 0 when not ready, zero register first, then forwarding.
    always_comb begin
      data = mem_q[addr];
      if (!ready) begin
        data = '0;
      end else if (ZERO_REG && (addr == '0)) begin
        data = '0;
      end else if (BYPASS && we && !clr && (a3 == addr)) begin
        data = wd3;
      end
    end

    assign rd[k*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: default bank, a no-forwarding copy sharing
// its inputs, and a small 8x16 three-port bank without a zero register.
module tb_reg_bank_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter bank (a) and BYPASS=0 copy (b) share stimulus.
  logic        rst_n;
  logic        we;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [9:0]  ra;
  logic        clr;
  logic [63:0] rd_a, rd_b;
  logic        ready_a, ready_b;

  // Small bank (c).
  logic        rst_c;
  logic        we_c;
  logic [2:0]  a3_c;
  logic [15:0] wd3_c;
  logic [8:0]  ra_c;
  logic        clr_c;
  logic [47:0] rd_c;
  logic        ready_c;

  reg_bank_mp dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .a3(a3), .wd3(wd3),
    .ra(ra), .rd(rd_a), .clr(clr), .ready(ready_a)
  );

  reg_bank_mp #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .a3(a3), .wd3(wd3),
    .ra(ra), .rd(rd_b), .clr(clr), .ready(ready_b)
  );

  reg_bank_mp #(.NREGS(8), .XLEN(16), .NRD(3), .ZERO_REG(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_c), .we(we_c), .a3(a3_c), .wd3(wd3_c),
    .ra(ra_c), .rd(rd_c), .clr(clr_c), .ready(ready_c)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  logic [15:0] rnd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    we = 1'b1; a3 = addr; wd3 = data;
    step();
    we = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  // Read all 32 registers through both ports of banks a and b.
  task automatic sweep(input string tag);
    for (int r = 0; r < 16; r++) begin
      ra = {5'(r + 16), 5'(r)};
      exp_q.push_back(model[r]);
      exp_q.push_back(model[r + 16]);
      exp_q.push_back(model[r]);
      exp_q.push_back(model[r + 16]);
      @(negedge clk);
      sb_pop({tag, "_a0"}, rd_a[31:0]);
      sb_pop({tag, "_a1"}, rd_a[63:32]);
      sb_pop({tag, "_b0"}, rd_b[31:0]);
      sb_pop({tag, "_b1"}, rd_b[63:32]);
      step();
    end
  endtask

  // Count edges after entering CLEAR; ready must rise exactly on edge n.
  task automatic clear_count(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      chk({tag, "_ready_a"}, 32'(ready_a), 32'(i == n));
      chk({tag, "_ready_b"}, 32'(ready_b), 32'(i == n));
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) model[r] = '0;
    rst_n = 1'b0; we = 1'b0; a3 = '0; wd3 = '0; ra = {5'd9, 5'd3}; clr = 1'b0;
    rst_c = 1'b0; we_c = 1'b0; a3_c = '0; wd3_c = '0; ra_c = '0; clr_c = 1'b0;

    // Reset held for two edges, then the initial sweep.
    repeat (2) step();
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_rd_a", rd_a[31:0] | rd_a[63:32], 32'd0);
    chk("rst_rd_b", rd_b[31:0] | rd_b[63:32], 32'd0);
    rst_n = 1'b1;
    clear_count("init", 32);

    // Directed writes, including the discarded write to register 0.
    wr(5'd10, 32'h12);
    wr(5'd5, 32'hF00F);
    wr(5'd21, 32'hABC);
    wr(5'd0, 32'hFFFF_FFFF);
    sweep("sweep1");

    // Same-cycle forwarding on both ports; bank b shows the old value.
    we = 1'b1; a3 = 5'd7; wd3 = 32'hDEAD; ra = {5'd7, 5'd7};
    exp_q.push_back(32'hDEAD); exp_q.push_back(32'hDEAD);
    exp_q.push_back(model[7]); exp_q.push_back(model[7]);
    @(negedge clk);
    sb_pop("byp_a0", rd_a[31:0]);
    sb_pop("byp_a1", rd_a[63:32]);
    sb_pop("nobyp_b0", rd_b[31:0]);
    sb_pop("nobyp_b1", rd_b[63:32]);
    step();
    we = 1'b0;
    model[7] = 32'hDEAD;
    exp_q.push_back(model[7]); exp_q.push_back(model[7]);
    @(negedge clk);
    sb_pop("after_b0", rd_b[31:0]);
    sb_pop("after_b1", rd_b[63:32]);
    step();

    // Writing register 0 must not forward either.
    we = 1'b1; a3 = 5'd0; wd3 = 32'h123; ra = {5'd0, 5'd0};
    @(negedge clk);
    chk("byp_zero_a", rd_a[31:0] | rd_a[63:32], 32'd0);
    step();
    we = 1'b0;

    // clr together with a write: the write is dropped and not forwarded.
    wr(5'd3, 32'h55);
    clr = 1'b1; we = 1'b1; a3 = 5'd4; wd3 = 32'h99; ra = {5'd4, 5'd3};
    exp_q.push_back(32'h55); exp_q.push_back(model[4]);
    @(negedge clk);
    sb_pop("clrwe_rd3", rd_a[31:0]);
    sb_pop("clrwe_rd4", rd_a[63:32]);
    step();
    clr = 1'b0; we = 1'b0;
    chk("clr_ready_a", 32'(ready_a), 32'd0);
    for (int r = 0; r < 32; r++) model[r] = '0;
    ra = {5'd10, 5'd3};
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) clr = 1'b1;
      if (i == 20) begin we = 1'b1; a3 = 5'd2; wd3 = 32'h77; end
      if (i == 5) begin
        @(negedge clk);
        chk("clearing_rd_a", rd_a[31:0] | rd_a[63:32], 32'd0);
      end
      step();
      clr = 1'b0; we = 1'b0;
      chk("clr_ready_a", 32'(ready_a), 32'(i == 32));
    end
    sweep("sweep2");

    // Reset in the middle of a sweep restarts it from index 0.
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (15) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready_a", 32'(ready_a), 32'd0);
    chk("midrst_rd_a", rd_a[31:0] | rd_a[63:32], 32'd0);
    clear_count("midrst", 32);

    // Small bank: 8-cycle clear, register 0 is ordinary storage.
    chk("c_rst_ready", 32'(ready_c), 32'd0);
    chk("c_rst_rd", 32'(rd_c[15:0] | rd_c[31:16] | rd_c[47:32]), 32'd0);
    rst_c = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("c_clear_ready", 32'(ready_c), 32'(i == 8));
    end
    we_c = 1'b1; a3_c = 3'd0; wd3_c = 16'hBEEF;
    step();
    we_c = 1'b0;
    ra_c = {3'd0, 3'd0, 3'd0};
    repeat (3) exp_q.push_back(32'hBEEF);
    @(negedge clk);
    sb_pop("c_rd0", 32'(rd_c[15:0]));
    sb_pop("c_rd1", 32'(rd_c[31:16]));
    sb_pop("c_rd2", 32'(rd_c[47:32]));
    step();
    rnd = 16'($urandom_range(1, 16'hFFFF));
    we_c = 1'b1; a3_c = 3'd5; wd3_c = rnd; ra_c = {3'd5, 3'd0, 3'd5};
    exp_q.push_back(32'(rnd)); exp_q.push_back(32'hBEEF); exp_q.push_back(32'(rnd));
    @(negedge clk);
    sb_pop("c_byp0", 32'(rd_c[15:0]));
    sb_pop("c_byp1", 32'(rd_c[31:16]));
    sb_pop("c_byp2", 32'(rd_c[47:32]));
    step();
    we_c = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
REG_BANK_MP -- requirements
Module: reg_bank_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: number of registers, a power of two and at least 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of independent read ports, at least 1.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port we, input, 1: write enable.
REQ-009 Port a3, input, AW: write address.
REQ-010 Port wd3, input, XLEN: write data.
REQ-011 Port ra, input, NRD*AW: packed read addresses; port k uses bits [k*AW +: AW].
REQ-012 Port rd, output, NRD*XLEN: packed read data; port k uses bits [k*XLEN +: XLEN].
REQ-013 Port clr, input, 1: single-cycle request to clear all registers.
REQ-014 Port ready, output, 1: high when the bank accepts writes and returns stored data.

Function
REQ-015 The bank SHALL have two states: CLEAR and READY.
REQ-016 In CLEAR, a counter idx SHALL start at 0 and write 0 to register idx each cycle, incrementing by 1.
REQ-017 When idx = NREGS-1 is cleared, the bank SHALL enter READY on that edge; the full clear takes exactly NREGS cycles.
REQ-018 ready SHALL be 0 in CLEAR and 1 in READY.
REQ-019 In READY, clr=1 SHALL enter CLEAR with idx=0 on the next edge.
REQ-020 In READY, clr=1 together with we=1 SHALL drop the write; clr has priority.
REQ-021 In CLEAR, we SHALL be ignored and clr SHALL have no effect; the sequence is not restarted.
REQ-022 In READY, we=1 SHALL write wd3 into register a3 at the rising edge.
REQ-023 When ZERO_REG=1, a write to address 0 SHALL be discarded.
REQ-024 Read ports SHALL be combinational and need no enable.
REQ-025 Port k SHALL return register ra[k], or 0 when ZERO_REG=1 and ra[k]=0.
REQ-026 When BYPASS=1, ready=1, we=1, clr=0 and a3 = ra[k] (and not 0 when ZERO_REG=1), port k SHALL return wd3 in the same cycle.
REQ-027 When BYPASS=0, port k SHALL return the stored value until the edge.
REQ-028 All rd outputs SHALL read 0 while ready=0.
REQ-029 Several ports with the same address SHALL return identical data.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force CLEAR with idx=0, regardless of the current state.
REQ-031 Reset SHALL therefore restart a clear that is already in progress.
REQ-032 Immediately after the reset edge, ready SHALL be 0 and all rd outputs SHALL be 0.
REQ-033 The first cycle with rst_n=1 SHALL clear register 0.
REQ-034 ready SHALL rise NREGS edges after rst_n is released.
REQ-035 Register contents SHALL not be reset in parallel; they are reset only by the CLEAR sweep.

Structure
REQ-036 Package reg_bank_pkg SHALL hold the state enum (CLEAR, READY) and the default parameter constants.
REQ-037 The clear sequencer (state, idx, ready) SHALL be the single sub-module reg_bank_clr.
REQ-038 Storage, write logic and read muxes SHALL stay in reg_bank_mp.

Verification
REQ-039 Defaults; hold rst_n=0 for 2 cycles, then release -> ready=0 for 32 cycles, rises on the 32nd edge; every ra reads 0.
REQ-040 Write 10<-0x12, 5<-0xF00F, 21<-0xABC, 0<-0xFFFFFFFF, then sweep all 32 registers over 2 ports -> listed values read back; reg 0 = 0; all others = 0.
REQ-041 BYPASS=1: we=1, a3=7, wd3=0xDEAD, ra0=7, ra1=7 -> both ports show 0xDEAD in the same cycle; with BYPASS=0 both show the old value until the edge.
REQ-042 After loading reg 3 = 0x55: pulse clr together with we (a3=4, wd3=0x99) -> reg 4 is not written; ready=0 for 32 cycles; then reg 3 = 0.
REQ-043 Drop rst_n for one cycle at idx=15 mid-clear -> idx restarts at 0; ready rises 32 edges after release.
REQ-044 NREGS=8, XLEN=16, NRD=3, ZERO_REG=0: write reg 0 = 0xBEEF -> reads back 0xBEEF on all 3 ports; clear takes 8 cycles.
